seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Upstream driver for the 7-segment decoder. Latches an 8-bit value, converts it to three display digits (hex passthrough or iterative binary-to-BCD), and time-multiplexes those digits onto a single `num`/`isHex` pair. The pair feeds the per-digit segment decoder; `digit_sel` drives the common digit enables. Sits between the RAM/UART data path and the display.

## Interface
Parameters:
- `SCAN_DIV`, default 50000: clock cycles each digit stays selected; legal range ≥1.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; one clock, asynchronous, active-low.
- `load`  in  1  single-cycle request to display `data`.
- `data`  in  8  value to display.
- `hex_mode`  in  1  1 = show `data` as hex, 0 = show as decimal.
- `busy`  out  1  decimal conversion in progress; `load` is ignored while high.
- `num`  out  4  digit code for the currently selected digit.
- `isHex`  out  1  mode of the currently displayed value (hex/decimal decode select).
- `digit_sel`  out  3  one-hot, active-high digit enable; bit 0 is the least significant digit.

## Operation
- Display registers: `disp[2:0]` (4 bits each) and `disp_hex`. Updated only at commit, all at once; the scanner never shows a partial result.
- FSM states:
  - IDLE: `busy`=0. On `load`=1 with `hex_mode`=1: commit `disp` = {0, data[7:4], data[3:0]} and `disp_hex`=1 on the same edge; stay in IDLE. On `load`=1 with `hex_mode`=0: capture `data` into the shift register, clear the BCD accumulator, go to CONV.
  - CONV: `busy`=1. Runs the double-dabble algorithm, 8 iterations, one per cycle. Each iteration:
    - add 3 to every BCD nibble ≥5;
    - shift {bcd, shreg} left by 1.
    - A 4-bit iteration counter runs 0..7. On the edge that completes iteration 7: commit `disp` = {hundreds, tens, ones} and `disp_hex`=0, then go to IDLE.
- `load` in CONV is dropped, not queued, including on the commit edge. `data` and `hex_mode` are sampled only on the accepting edge.
- BCD accumulator is 12 bits; 255 → 0x255, so there is no overflow.
- Scanner:
  - Free-running counter 0..SCAN_DIV-1. On the terminal count, the counter wraps to 0 and the digit index advances 0→1→2→0.
  - The scanner is independent of the FSM; loads do not reset it.
- Outputs:
  - `digit_sel` = 1<<idx; `num` = disp[idx]; `isHex` = disp_hex.
  - These are combinational muxes of registers only; there are no input-to-output combinational paths.
- Reset (async, `rst`=0):
  - state IDLE, `busy`=0, scan counter 0, idx 0;
  - `disp`=0, `disp_hex`=0;
  - therefore `num`=0, `isHex`=0, `digit_sel`=3'b001.
  - Reset during CONV aborts the conversion; nothing is committed.

## Timing
- `load` accepted at edge T:
  - Hex: new `num`/`isHex` are visible after edge T (latency 1).
  - Decimal: `busy`=1 after edge T through edge T+8. Commit occurs at edge T+8; `busy`=0 and new digits are visible after T+8. `busy` is high for exactly 8 cycles.
- Earliest next accepted `load`: edge T+1 (hex) or edge T+9 (decimal).
- With SCAN_DIV=N, each digit is selected for exactly N cycles. SCAN_DIV=1 advances every cycle.

## Structure
- Shared package `seg_pkg`:
  - `SEG_DIGITS`=3 and `BCD_W`=4;
  - FSM state typedef (IDLE, CONV);
  - digit index width.
- Sub-module `bin2bcd8`: the iterative double-dabble engine (start/busy/done handshake, 8-bit in, 12-bit BCD out). The FSM wraps it and performs the commit.
- The scanner stays inline.

## Test plan
- Hex: reset, then `load`=1, `data`=0xA7, `hex_mode`=1 → next cycle `disp` = {0,A,7} and `isHex`=1; `busy` never rises.
- Decimal: `load` with `data`=255, `hex_mode`=0 → `busy` high for exactly 8 cycles, then digits {2,5,5} and `isHex`=0. Repeat with 0 → {0,0,0}, 100 → {1,0,0}, 9 → {0,0,9}.
- Dropped load: `load` 200 (decimal), then `load` 0x3C hex at T+3 and at T+8 → 200 is displayed as {2,0,0}; both later loads are ignored. A `load` at T+9 is accepted.
- Scan with SCAN_DIV=4, `disp`={1,2,3}:
  - `digit_sel` 001 / `num`=3 for 4 cycles;
  - then 010 / `num`=2 for 4 cycles;
  - then 100 / `num`=1 for 4 cycles;
  - then back to 001.
- Reset mid-conversion: assert `rst`=0 at T+4 of a decimal load → `busy`=0, `num`=0, `isHex`=0, `digit_sel`=001 immediately. After release, no stale commit occurs.
- Hex then decimal back-to-back: load 0xFF hex at T and 37 decimal at T+1 → {0,F,F} `isHex`=1 visible T+1..T+9, then {0,3,7} `isHex`=0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan driver: digit geometry, FSM
// states and the double-dabble nibble adjustment.
package seg_pkg;

   localparam int SEG_DIGITS = 3;
   localparam int BCD_W      = 4;
   localparam int IDX_W      = 2;
   localparam int BIN_W      = 8;
   localparam int ACC_W      = SEG_DIGITS * BCD_W;
   localparam int CONV_ITERS = 8;

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_t;

   typedef logic [IDX_W-1:0] idx_t;

   // A nibble of 5 or more would exceed 9 after the next doubling.
   function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] nib);
      return (nib >= BCD_W'(5)) ? nib + BCD_W'(3) : nib;
   endfunction

endpackage

// File: rtl/bin2bcd8.sv
// Iterative double-dabble engine: one adjust+shift per cycle, 8 cycles per
// conversion. bcd carries the finished result on the cycle done is high.
module bin2bcd8
   import seg_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [BIN_W-1:0] din,
   output logic             busy,
   output logic             done,
   output logic [ACC_W-1:0] bcd
);

   logic [BIN_W-1:0]       shreg;
   logic [ACC_W-1:0]       acc;
   logic [3:0]             iter;
   logic [ACC_W-1:0]       acc_adj;
   logic [ACC_W+BIN_W-1:0] shifted;

   always_comb begin
      acc_adj = '0;
      for (int i = 0; i < SEG_DIGITS; i++) begin
         acc_adj[i*BCD_W +: BCD_W] = dabble_adjust(acc[i*BCD_W +: BCD_W]);
      end
      shifted = {acc_adj, shreg} << 1;
   end

   // The result is exposed combinationally so the owner can commit it on the
   // same edge that completes the last iteration.
   assign done = busy && (iter == 4'(CONV_ITERS - 1));
   assign bcd  = shifted[ACC_W+BIN_W-1:BIN_W];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy  <= 1'b0;
         shreg <= '0;
         acc   <= '0;
         iter  <= '0;
      end else if (busy) begin
         shreg <= shifted[BIN_W-1:0];
         acc   <= shifted[ACC_W+BIN_W-1:BIN_W];
         iter  <= iter + 4'd1;
         if (done) begin
            busy <= 1'b0;
         end
      end else if (start) begin
         shreg <= din;
         acc   <= '0;
         iter  <= '0;
         busy  <= 1'b1;
      end
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Latches a byte, shows it as hex or decimal on three multiplexed digits,
// and scans the digit enables at a fixed dwell of SCAN_DIV clocks.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int SCAN_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [BIN_W-1:0]      data,
   input  logic                  hex_mode,
   output logic                  busy,
   output logic [BCD_W-1:0]      num,
   output logic                  isHex,
   output logic [SEG_DIGITS-1:0] digit_sel
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   state_t state, state_next;
   logic   conv_start;
   logic   hex_commit;
   logic   eng_busy;
   logic   eng_done;
   logic [ACC_W-1:0] eng_bcd;

   logic [SEG_DIGITS-1:0][BCD_W-1:0] disp;
   logic                             disp_hex;

   logic [CNT_W-1:0] scan_cnt;
   idx_t             idx;
   logic             scan_tc;

   bin2bcd8 u_bin2bcd8 (
      .clk   (clk),
      .rst   (rst),
      .start (conv_start),
      .din   (data),
      .busy  (eng_busy),
      .done  (eng_done),
      .bcd   (eng_bcd)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Loads arriving during CONV are dropped, never queued.
   always_comb begin
      state_next = state;
      conv_start = 1'b0;
      hex_commit = 1'b0;
      case (state)
         IDLE: begin
            if (load) begin
               if (hex_mode) begin
                  hex_commit = 1'b1;
               end else if (!eng_busy) begin
                  conv_start = 1'b1;
                  state_next = CONV;
               end
            end
         end
         CONV: begin
            if (eng_done) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state == CONV);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         disp     <= '0;
         disp_hex <= 1'b0;
      end else if (hex_commit) begin
         disp     <= {BCD_W'(0), data[7:4], data[3:0]};
         disp_hex <= 1'b1;
      end else if (eng_done) begin
         disp     <= eng_bcd;
         disp_hex <= 1'b0;
      end
   end

   // Free-running scanner, deliberately untouched by loads.
   assign scan_tc = (scan_cnt == CNT_W'(SCAN_DIV - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scan_cnt <= '0;
         idx      <= '0;
      end else if (scan_tc) begin
         scan_cnt <= '0;
         idx      <= (idx == IDX_W'(SEG_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   always_comb begin
      num = '0;
      if (idx < IDX_W'(SEG_DIGITS)) begin
         num = disp[idx];
      end
      digit_sel = SEG_DIGITS'(1) << idx;
      isHex     = disp_hex;
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: a scoreboard of expected display
// contents, applied at their predicted commit edge, is checked every cycle.
module tb_seg_scan_driver;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       load;
   logic [7:0] data;
   logic       hex_mode;
   logic       busy;
   logic [3:0] num;
   logic       isHex;
   logic [2:0] digit_sel;

   seg_scan_driver #(.SCAN_DIV(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .data      (data),
      .hex_mode  (hex_mode),
      .busy      (busy),
      .num       (num),
      .isHex     (isHex),
      .digit_sel (digit_sel)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         at_edge;
      logic [11:0] digits;
      logic       hex;
   } exp_t;

   exp_t        sb[$];
   int          cyc;
   int          n_checks;
   int          n_errors;
   int          commit_edge;
   int          sc_cnt;
   int          sc_idx;
   logic [11:0] exp_disp;
   logic        exp_hex;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("[TB] FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_output();
      logic [2:0] exp_sel;
      logic       exp_busy;
      exp_sel  = 3'b001 << sc_idx;
      exp_busy = (cyc >= commit_edge - 8) && (cyc < commit_edge);
      check("digit_sel", 8'(digit_sel), 8'(exp_sel));
      check("num", 8'(num), 8'(exp_disp[sc_idx*4 +: 4]));
      check("isHex", 8'(isHex), 8'(exp_hex));
      check("busy", 8'(busy), 8'(exp_busy));
   endtask

   task automatic model_reset();
      sb.delete();
      exp_disp    = '0;
      exp_hex     = 1'b0;
      sc_cnt      = 0;
      sc_idx      = 0;
      commit_edge = -100;
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      if (rst) begin
         if (sc_cnt == N - 1) begin
            sc_cnt = 0;
            sc_idx = (sc_idx + 1) % 3;
         end else begin
            sc_cnt++;
         end
      end
      while (sb.size() > 0 && sb[0].at_edge <= cyc) begin
         exp_disp = sb[0].digits;
         exp_hex  = sb[0].hex;
         void'(sb.pop_front());
      end
      @(negedge clk);
      check_output();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // A load is accepted only if its edge falls after the last decimal commit edge.
   task automatic apply_stimulus(input logic [7:0] d, input logic h);
      int   e;
      exp_t x;
      e        = cyc + 1;
      load     = 1'b1;
      data     = d;
      hex_mode = h;
      if (e > commit_edge) begin
         if (h) begin
            x.at_edge = e;
            x.digits  = {4'h0, d};
            x.hex     = 1'b1;
         end else begin
            x.at_edge   = e + 8;
            x.digits    = {4'(d / 100), 4'((d / 10) % 10), 4'(d % 10)};
            x.hex       = 1'b0;
            commit_edge = e + 8;
         end
         sb.push_back(x);
      end
      tick();
      load = 1'b0;
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      #1;
      model_reset();
      check_output();
      ticks(2);
      rst = 1'b1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst      = 1'b1;
      load     = 1'b0;
      data     = '0;
      hex_mode = 1'b0;
      cyc      = 0;
      n_checks = 0;
      n_errors = 0;
      model_reset();
      @(negedge clk);
      apply_reset();

      $display("[TB] hex load 0xA7");
      apply_stimulus(8'hA7, 1'b1);
      ticks(12);

      $display("[TB] decimal loads 255, 0, 100, 9");
      apply_stimulus(8'd255, 1'b0);
      ticks(14);
      apply_stimulus(8'd0, 1'b0);
      ticks(14);
      apply_stimulus(8'd100, 1'b0);
      ticks(14);
      apply_stimulus(8'd9, 1'b0);
      ticks(14);

      $display("[TB] loads during conversion are dropped");
      apply_stimulus(8'd200, 1'b0);
      ticks(2);
      apply_stimulus(8'h3C, 1'b1);
      ticks(4);
      apply_stimulus(8'h3C, 1'b1);
      apply_stimulus(8'd42, 1'b0);
      ticks(14);

      $display("[TB] scan dwell with display 123");
      apply_stimulus(8'd123, 1'b0);
      ticks(20);

      $display("[TB] reset during conversion");
      apply_stimulus(8'd77, 1'b0);
      ticks(3);
      apply_reset();
      ticks(14);

      $display("[TB] hex then decimal back to back");
      apply_stimulus(8'hFF, 1'b1);
      apply_stimulus(8'd37, 1'b0);
      ticks(14);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
